// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the PWM duty ramp generator: duty width, mode
// encodings, FSM state type and the saturating duty step helpers.
package pwm_ramp_pkg;

    localparam int unsigned DUTY_W = 16;

    localparam logic MODE_SINGLE  = 1'b0;
    localparam logic MODE_BREATHE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        BR_UP,
        BR_DOWN
    } state_t;

    // Move d up by s, clamped at lim. A value already above lim drops to lim.
    // s == 0 means full span: land on lim in one step.
    function automatic logic [DUTY_W-1:0] sat_up(
        input logic [DUTY_W-1:0] d,
        input logic [DUTY_W-1:0] s,
        input logic [DUTY_W-1:0] lim
    );
        logic [DUTY_W:0] sum;
        sum = {1'b0, d} + {1'b0, s};
        if (s == '0 || sum >= {1'b0, lim}) begin
            return lim;
        end
        return sum[DUTY_W-1:0];
    endfunction

    // Move d down by s, clamped at lim. Bit DUTY_W of the 17-bit difference
    // flags a borrow, which also clamps. s == 0 lands on lim in one step.
    function automatic logic [DUTY_W-1:0] sat_down(
        input logic [DUTY_W-1:0] d,
        input logic [DUTY_W-1:0] s,
        input logic [DUTY_W-1:0] lim
    );
        logic [DUTY_W:0] diff;
        diff = {1'b0, d} - {1'b0, s};
        if (s == '0 || diff[DUTY_W] || diff[DUTY_W-1:0] <= lim) begin
            return lim;
        end
        return diff[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_ramp_period_ticker.sv
// PWM period counter with a registered end-of-period tick.
//   clk    : clock
//   rst    : synchronous active-high reset
//   period : PWM period in clk cycles, sampled live
//   tick   : high for one cycle while the counter holds period-1
//            (every cycle when period is 0 or 1)
module period_ticker
    import pwm_ramp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] period,
    output logic              tick
);

    logic [DUTY_W-1:0] count;
    logic [DUTY_W-1:0] count_next;
    logic [DUTY_W-1:0] last;

    always_comb begin
        last       = (period > 16'd1) ? period - 16'd1 : '0;
        count_next = (count >= last) ? '0 : count + 16'd1;
    end

    // The tick is registered, so it is computed from the count the
    // counter is about to hold rather than the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count_next;
            tick  <= (count_next == last);
        end
    end

endmodule

// File: rtl/pwm_ramp.sv
// Duty-cycle ramp generator feeding a downstream PWM. Steps duty_cycle
// toward a latched target once per PWM period, either as a single ramp or
// as a continuous target <-> 0 breathe.
//   clk, rst    : clock, synchronous active-high reset
//   period      : PWM period (shared with the PWM stage)
//   start, stop : one-cycle command pulses (stop wins)
//   target, step, mode : ramp parameters, latched on start
//   duty_cycle  : registered duty value
//   period_tick : end-of-period strobe
//   busy, done  : not idle / single ramp completed pulse
module pwm_ramp
    import pwm_ramp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] period,
    input  logic              start,
    input  logic              stop,
    input  logic [DUTY_W-1:0] target,
    input  logic [DUTY_W-1:0] step,
    input  logic              mode,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              period_tick,
    output logic              busy,
    output logic              done
);

    state_t            state, state_next;
    logic [DUTY_W-1:0] duty_next;
    logic [DUTY_W-1:0] tgt, tgt_next;
    logic [DUTY_W-1:0] stp, stp_next;
    logic              done_next;

    period_ticker u_ticker (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .tick   (period_tick)
    );

    assign busy = (state != IDLE);

    // The latched mode is carried by the state chosen on start
    // (RAMP vs BR_UP), so no separate mode register is kept.
    always_comb begin
        state_next = state;
        duty_next  = duty_cycle;
        tgt_next   = tgt;
        stp_next   = stp;
        done_next  = 1'b0;
        if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            tgt_next   = target;
            stp_next   = step;
            state_next = (mode == MODE_BREATHE) ? BR_UP : RAMP;
        end else if (period_tick) begin
            case (state)
                RAMP: begin
                    duty_next = (duty_cycle <= tgt) ? sat_up(duty_cycle, stp, tgt)
                                                    : sat_down(duty_cycle, stp, tgt);
                    if (duty_next == tgt) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                BR_UP: begin
                    duty_next = sat_up(duty_cycle, stp, tgt);
                    if (duty_next == tgt) begin
                        state_next = BR_DOWN;
                    end
                end
                BR_DOWN: begin
                    duty_next = sat_down(duty_cycle, stp, '0);
                    if (duty_next == '0) begin
                        state_next = BR_UP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= '0;
            tgt        <= '0;
            stp        <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            duty_cycle <= duty_next;
            tgt        <= tgt_next;
            stp        <= stp_next;
            done       <= done_next;
        end
    end

endmodule

// File: tb/tb_pwm_ramp.sv
// Bench for pwm_ramp: stimulus pushes the expected post-tick duty/done/busy
// and tick spacing; a monitor pops one entry per observed period tick.
module tb_pwm_ramp;
    import pwm_ramp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] period = 16'd10;
    logic [15:0] target = '0;
    logic [15:0] step = '0;
    logic [15:0] duty_cycle;
    logic        period_tick;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] duty;
        logic        done;
        logic        busy;
        int unsigned gap;
    } exp_t;

    exp_t q[$];

    pwm_ramp dut (
        .clk         (clk),
        .rst         (rst),
        .period      (period),
        .start       (start),
        .stop        (stop),
        .target      (target),
        .step        (step),
        .mode        (mode),
        .duty_cycle  (duty_cycle),
        .period_tick (period_tick),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [15:0] d, input logic dn, input logic b,
                                 input int unsigned g);
        exp_t e;
        e.duty = d;
        e.done = dn;
        e.busy = b;
        e.gap  = g;
        q.push_back(e);
    endfunction

    // Monitor: the cycle after each tick carries the updated duty and done.
    int unsigned cyc = 0;
    int unsigned last_tick = 0;
    logic        tick_prev = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        cyc++;
        if (tick_prev) begin
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("sb_duty", {16'd0, duty_cycle}, {16'd0, mon_e.duty});
                chk("sb_done", {31'd0, done}, {31'd0, mon_e.done});
                chk("sb_busy", {31'd0, busy}, {31'd0, mon_e.busy});
                if (mon_e.gap != 0) chk("sb_gap", cyc - last_tick, mon_e.gap);
            end
            last_tick = cyc;
        end
        tick_prev = period_tick;
    end

    task automatic drain(input int unsigned max_cyc);
        int unsigned n = 0;
        while (q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        q.delete();
        #1;
    endtask

    task automatic sync();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 200);
        chk("sync_tick", {31'd0, period_tick}, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] t, input logic [15:0] s, input logic m);
        target = t;
        step   = s;
        mode   = m;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        target = 16'h1234;
        step   = 16'h0001;
        mode   = ~m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_duty", {16'd0, duty_cycle}, 0);
        chk("rst_tick", {31'd0, period_tick}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single ramp up; inputs scrambled after start must be ignored.
        sync();
        push(16'd10, 1'b0, 1'b1, 10);
        push(16'd20, 1'b0, 1'b1, 10);
        push(16'd30, 1'b1, 1'b0, 10);
        pulse_start(16'd30, 16'd10, MODE_SINGLE);
        drain(60);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 0);

        // Ramp down with saturation at target.
        sync();
        push(16'd20, 1'b0, 1'b1, 10);
        push(16'd10, 1'b0, 1'b1, 10);
        push(16'd5,  1'b1, 1'b0, 10);
        pulse_start(16'd5, 16'd10, MODE_SINGLE);
        drain(60);

        // Already at target: done at first tick, duty unchanged.
        sync();
        push(16'd5, 1'b1, 1'b0, 10);
        pulse_start(16'd5, 16'd3, MODE_SINGLE);
        drain(30);

        // step 0 jumps straight to target.
        sync();
        push(16'd100, 1'b1, 1'b0, 10);
        pulse_start(16'd100, 16'd0, MODE_SINGLE);
        drain(30);

        // Back to 0, then saturate at FFFF and at 0 with a huge step.
        sync();
        push(16'd0, 1'b1, 1'b0, 10);
        pulse_start(16'd0, 16'd0, MODE_SINGLE);
        drain(30);
        sync();
        push(16'hF000, 1'b0, 1'b1, 10);
        push(16'hFFFF, 1'b1, 1'b0, 10);
        pulse_start(16'hFFFF, 16'hF000, MODE_SINGLE);
        drain(40);
        sync();
        push(16'h0FFF, 1'b0, 1'b1, 10);
        push(16'h0000, 1'b1, 1'b0, 10);
        pulse_start(16'h0000, 16'hF000, MODE_SINGLE);
        drain(40);

        // Mid-ramp start and stop together: stop wins, duty holds, no done.
        sync();
        push(16'd10, 1'b0, 1'b1, 10);
        pulse_start(16'd50, 16'd10, MODE_SINGLE);
        drain(30);
        stop = 1'b1;
        pulse_start(16'd77, 16'd7, MODE_SINGLE);
        stop = 1'b0;
        @(negedge clk);
        chk("stopstart_busy", {31'd0, busy}, 0);
        chk("stopstart_done", {31'd0, done}, 0);
        push(16'd10, 1'b0, 1'b0, 10);
        drain(30);

        // Restart while busy: continues from current duty with new target.
        sync();
        push(16'd20, 1'b0, 1'b1, 10);
        pulse_start(16'd50, 16'd10, MODE_SINGLE);
        drain(30);
        push(16'd25, 1'b1, 1'b0, 10);
        pulse_start(16'd25, 16'd10, MODE_SINGLE);
        drain(30);

        // Reset mid-ramp overrides start and stop.
        sync();
        push(16'd35, 1'b0, 1'b1, 10);
        pulse_start(16'd100, 16'd10, MODE_SINGLE);
        drain(30);
        rst   = 1'b1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_duty", {16'd0, duty_cycle}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_tick", {31'd0, period_tick}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        chk("postrst_busy", {31'd0, busy}, 0);
        chk("postrst_duty", {16'd0, duty_cycle}, 0);
        push(16'd0, 1'b0, 1'b0, 0);
        push(16'd0, 1'b0, 1'b0, 10);
        drain(40);

        // Breathe at period 4, then stop.
        period = 16'd4;
        sync();
        push(16'd4, 1'b0, 1'b1, 4);
        push(16'd8, 1'b0, 1'b1, 4);
        push(16'd4, 1'b0, 1'b1, 4);
        push(16'd0, 1'b0, 1'b1, 4);
        push(16'd4, 1'b0, 1'b1, 4);
        push(16'd8, 1'b0, 1'b1, 4);
        pulse_start(16'd8, 16'd4, MODE_BREATHE);
        drain(40);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        chk("br_stop_busy", {31'd0, busy}, 0);
        chk("br_stop_done", {31'd0, done}, 0);
        push(16'd8, 1'b0, 1'b0, 4);
        push(16'd8, 1'b0, 1'b0, 4);
        drain(20);

        // Degenerate periods: tick every cycle.
        period = 16'd1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) push(16'd8, 1'b0, 1'b0, 1);
        drain(20);
        period = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) push(16'd8, 1'b0, 1'b0, 1);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_ramp.md
PWM_RAMP -- requirements
Module: pwm_ramp

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 period  input  16  PWM period in clk cycles, same value driven to the downstream PWM; sampled live.
REQ-004 start  input  1  one-cycle pulse; latches target, step, mode and begins a ramp.
REQ-005 stop  input  1  one-cycle pulse; aborts any ramp, duty_cycle holds.
REQ-006 target  input  16  ramp end value for duty_cycle.
REQ-007 step  input  16  duty increment or decrement per PWM period; 0 = jump to target on first tick.
REQ-008 mode  input  1  0 = single ramp, 1 = breathe (target <-> 0, continuous).
REQ-009 duty_cycle  output  16  registered duty value feeding the PWM duty_cycle input.
REQ-010 period_tick  output  1  registered; high for one cycle at the last count of each PWM period.
REQ-011 busy  output  1  high in any non-IDLE state.
REQ-012 done  output  1  one-cycle pulse when a single-mode ramp reaches target.

Function
REQ-013 Period counter: 16-bit, runs in all states, counts 0..period-1 and then wraps to 0; same wrap rule as the PWM (wrap when count >= period-1).
REQ-014 period 0 or 1: counter stays 0; period_tick is high every cycle.
REQ-015 period_tick = 1 in the cycle the counter holds period-1; duty_cycle updates on that edge, so the new duty is valid when the PWM counter returns to 0.
REQ-016 FSM states: IDLE, RAMP, BR_UP, BR_DOWN.
REQ-017 IDLE + start: mode 0 -> RAMP; mode 1 -> BR_UP; parameters latched on the start edge.
REQ-018 RAMP, on each tick: duty moves toward latched target by step; the result is saturated at target.
REQ-019 RAMP: in the tick where duty reaches target -> IDLE, with done pulsed in the next cycle.
REQ-020 RAMP: duty == target already at start -> done at the first tick, duty unchanged.
REQ-021 BR_UP, each tick: duty += step, saturated at target; on reaching target -> BR_DOWN.
REQ-022 BR_DOWN, each tick: duty -= step, saturated at 0; on reaching 0 -> BR_UP.
REQ-023 Breathe mode never asserts done; it runs until stop or rst.
REQ-024 Arithmetic: use a 17-bit intermediate; no wrap-around at 16'hFFFF or below 0, under any step value.
REQ-025 step == 0 is treated as full span: duty jumps to the limit in one tick.
REQ-026 start while busy: relatch parameters and re-enter RAMP or BR_UP from the current duty; there is no jump and no done for the aborted ramp.
REQ-027 stop: -> IDLE next cycle; duty_cycle holds; no done.
REQ-028 stop and start in the same cycle: stop wins.
REQ-029 stop in IDLE: no effect.
REQ-030 Changes to target, step or mode after start have no effect until the next start.

Reset
REQ-031 rst: state=IDLE, counter=0, duty_cycle=0, period_tick=0, busy=0, done=0, latched parameters=0.
REQ-032 rst asserted mid-ramp overrides start and stop; the block resumes in IDLE in the first cycle after rst drops.

Structure
REQ-033 A shared package holds the FSM state enum, the width constant DUTY_W=16 and the mode encodings (MODE_SINGLE, MODE_BREATHE).
REQ-034 The period counter and tick are a sub-module period_ticker (inputs clk, rst, period; output tick), reusable by the PWM stage.
REQ-035 The top level holds the FSM, the parameter latches and the saturating duty arithmetic; it has no other sub-modules.

Verification
REQ-036 Reset, then period=10, start, mode=0, target=30, step=10: ticks every 10 cycles; duty 10, 20, 30 on the three ticks; done 1 cycle after the third tick; busy falls.
REQ-037 Duty=30, then start with target=5, step=10: duty 20, 10, 5 (saturated), then done; no underflow.
REQ-038 period=4, start, mode=1, target=8, step=4: duty 4, 8, 4, 0, 4, 8 ...; done never high; stop -> duty holds and busy falls next cycle.
REQ-039 Start with target=16'hFFFF, step=16'hF000: duty F000 then FFFF, no wrap; step=0, target=100: duty=100 at first tick.
REQ-040 Mid-ramp start and stop in the same cycle -> IDLE, no done; rst mid-ramp -> all outputs 0 the cycle after; period=0 or 1 -> period_tick high every cycle.
